// File: rtl/pn_sequence_checker.sv
// PN sequence checker: self-synchronising Fibonacci LFSR receiver with lock detection and BER counters.
// Optional macro PN_CHK_STATS_EN enables the bit_cnt statistics counter and joint err/bit freeze.
module pn_sequence_checker #(
    parameter int                LFSR_W     = 3,
    parameter logic [LFSR_W-1:0] TAPS       = 3'b110,
    parameter int                LOCK_CNT   = 8,
    parameter int                UNLOCK_ERR = 4,
    parameter int                ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pn_valid,
    input  logic             pn_bit,
    output logic             pn_ready,
    input  logic             clear,
    output logic             locked,
    output logic [1:0]       state,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] bit_cnt
);
    localparam int FILL_W  = $clog2(LFSR_W + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int RUN_W   = $clog2(UNLOCK_ERR + 1);
    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_SEARCH = 2'b00,
        S_VERIFY = 2'b01,
        S_LOCKED = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_pulse_q, err_pulse_d;
    logic               accept, pred, mism, cnt_en;

    assign pn_ready = reset & ~clear;
    assign accept   = pn_valid & pn_ready;
    assign pred     = ^(sr_q & TAPS);
    assign mism     = pn_bit ^ pred;

`ifdef PN_CHK_STATS_EN
    logic [ERR_W-1:0] bit_cnt_q, bit_cnt_d;
    // Both counters stop together so err/bit stays a meaningful ratio.
    assign cnt_en  = (err_cnt_q != CNT_MAX) && (bit_cnt_q != CNT_MAX);
    assign bit_cnt = bit_cnt_q;
`else
    assign cnt_en  = (err_cnt_q != CNT_MAX);
    assign bit_cnt = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_SEARCH;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            run_q       <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
`ifdef PN_CHK_STATS_EN
            bit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            run_q       <= run_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
`ifdef PN_CHK_STATS_EN
            bit_cnt_q   <= bit_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        run_d       = run_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
`ifdef PN_CHK_STATS_EN
        bit_cnt_d   = bit_cnt_q;
`endif
        if (clear) begin
            state_d   = S_SEARCH;
            sr_d      = '0;
            fill_d    = '0;
            match_d   = '0;
            run_d     = '0;
            err_cnt_d = '0;
`ifdef PN_CHK_STATS_EN
            bit_cnt_d = '0;
`endif
        end else if (accept) begin
            case (state_q)
                S_SEARCH: begin
                    sr_d = {sr_q[LFSR_W-2:0], pn_bit};
                    if (fill_q == FILL_W'(LFSR_W - 1)) begin
                        state_d = S_VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                S_VERIFY: begin
                    sr_d = {sr_q[LFSR_W-2:0], pn_bit};
                    if (mism) begin
                        // The offending bit is kept as the first bit of the new fill.
                        state_d = S_SEARCH;
                        fill_d  = FILL_W'(1);
                        match_d = '0;
                    end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                        state_d = S_LOCKED;
                        match_d = '0;
                        run_d   = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                S_LOCKED: begin
                    // Free-run on the prediction so channel errors never enter the register.
                    sr_d = {sr_q[LFSR_W-2:0], pred};
`ifdef PN_CHK_STATS_EN
                    if (cnt_en) bit_cnt_d = bit_cnt_q + 1'b1;
`endif
                    if (mism) begin
                        err_pulse_d = 1'b1;
                        if (cnt_en) err_cnt_d = err_cnt_q + 1'b1;
                        if (run_q == RUN_W'(UNLOCK_ERR - 1)) begin
                            state_d = S_SEARCH;
                            fill_d  = '0;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                default: state_d = S_SEARCH;
            endcase
        end
    end

    assign locked    = (state_q == S_LOCKED);
    assign state     = state_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
endmodule
